// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-image loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN0,
        ST_LEN1,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0]  SYNC0_BYTE        = 8'hA5;
    localparam logic [7:0]  SYNC1_BYTE        = 8'h5A;
    localparam int unsigned MAX_WORDS_DEFAULT = 8192;
    localparam int unsigned LEN_W             = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs four accepted bytes little-endian into a 32-bit word.
// The word and its completion strobe are presented combinationally with
// the fourth byte so the parent can register them in the same edge.
module word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word_c,
    output logic        word_done_c
);

    logic [1:0]  idx;
    logic [23:0] low_bytes;

    // Byte index and the three lower bytes of the word in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            idx       <= 2'd0;
            low_bytes <= 24'd0;
        end else if (en) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    low_bytes[7:0]   <= data;
                2'd1:    low_bytes[15:8]  <= data;
                2'd2:    low_bytes[23:16] <= data;
                default: ;
            endcase
        end
    end

    assign word_c      = {data, low_bytes};
    assign word_done_c = en && (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream boot loader: receives a framed image, writes it word by word
// into the combined memory, verifies the XOR checksum and releases the core.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int unsigned LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         len_lo_q;
    logic [LEN_W-1:0]   n_words_q;
    logic [7:0]         checksum_q;
    logic [LEN_W-1:0]   len_c;
    logic               accept_c;
    logic               restart_c;
    logic               last_word_c;
    logic               asm_clear_c;
    logic               asm_en_c;
    logic [31:0]        word_c;
    logic               word_done_c;

    assign accept_c    = in_valid && in_ready;
    assign len_c       = {in_data, len_lo_q};
    assign restart_c   = start && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign last_word_c = (32'(words_loaded) + 32'd1) == 32'(n_words_q);
    assign asm_clear_c = (state_q != ST_PAYLOAD);
    assign asm_en_c    = accept_c && (state_q == ST_PAYLOAD);

    word_assembler u_word_assembler (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (asm_clear_c),
        .en          (asm_en_c),
        .data        (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // State register plus state-decoded status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SYNC0;
            in_ready   <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready   <= (state_d != ST_DONE) && (state_d != ST_ERROR);
            core_reset <= (state_d != ST_DONE);
            done       <= (state_d == ST_DONE);
            error      <= (state_d == ST_ERROR);
        end
    end

    // Frame parser next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC0: begin
                if (accept_c && (in_data == SYNC0_BYTE)) state_d = ST_SYNC1;
            end
            ST_SYNC1: begin
                if (accept_c) begin
                    if (in_data == SYNC1_BYTE)      state_d = ST_LEN0;
                    else if (in_data == SYNC0_BYTE) state_d = ST_SYNC1;
                    else                            state_d = ST_SYNC0;
                end
            end
            ST_LEN0: begin
                if (accept_c) state_d = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept_c) begin
                    if (32'(len_c) > MAX_WORDS)   state_d = ST_ERROR;
                    else if (len_c == LEN_W'(0))  state_d = ST_CHECK;
                    else                          state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (word_done_c && last_word_c) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept_c) state_d = (in_data == checksum_q) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_SYNC0;
            end
            default: state_d = ST_SYNC0;
        endcase
    end

    // Length capture, checksum, word counter and memory write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_lo_q     <= 8'd0;
            n_words_q    <= '0;
            checksum_q   <= 8'd0;
            words_loaded <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (state_q == ST_LEN0 && accept_c) len_lo_q  <= in_data;
            if (state_q == ST_LEN1 && accept_c) n_words_q <= len_c;
            if (restart_c) begin
                words_loaded <= '0;
                checksum_q   <= 8'd0;
            end else begin
                // Count advances on the strobe cycle, so mem_addr uses the pre-increment value.
                if (mem_we)   words_loaded <= words_loaded + CNT_W'(1);
                if (asm_en_c) checksum_q   <= checksum_q ^ in_data;
                if (word_done_c) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ADDR_W'(LOAD_BASE) + words_loaded[ADDR_W-1:0];
                    mem_wdata <= word_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued by
// the stimulus and checked by an independent write monitor.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int total = 0;
    int passed = 0;

    logic [45:0] exp_q[$];
    logic [7:0]  tx[$];

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(8192), .LOAD_BASE(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e)
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, e[45:32], e[31:0]);
                else passed++;
            end
        end
    end

    // Send the tx queue, optionally with random idle gaps between bytes.
    task automatic send_tx(input int max_gap);
        foreach (tx[i]) begin
            int gap;
            bit ok;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = tx[i];
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (in_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (!ok) begin
                total++;
                $display("FAIL accept_timeout: got no in_ready expected in_ready for byte %0d", i);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check("rst_in_ready",   32'(in_ready),     32'd1);
        check("rst_core_reset", 32'(core_reset),   32'd1);
        check("rst_done",       32'(done),         32'd0);
        check("rst_error",      32'(error),        32'd0);
        check("rst_mem_we",     32'(mem_we),       32'd0);
        check("rst_words",      32'(words_loaded), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);

        // Good two-word frame; XOR of payload bytes is 0x87.
        expect_write(14'd0, 32'h0080_0513);
        expect_write(14'd1, 32'h0080_0293);
        tx = {8'hA5, 8'h5A, 8'h02, 8'h00, 8'h13, 8'h05, 8'h80, 8'h00,
              8'h93, 8'h02, 8'h80, 8'h00, 8'h87};
        send_tx(0);
        idle(2);
        check("f1_done",       32'(done),         32'd1);
        check("f1_core_reset", 32'(core_reset),   32'd0);
        check("f1_in_ready",   32'(in_ready),     32'd0);
        check("f1_words",      32'(words_loaded), 32'd2);
        check("f1_sb_empty",   32'(exp_q.size()), 32'd0);

        // Same frame with a bad checksum.
        pulse_start();
        check("rearm_core_reset", 32'(core_reset), 32'd1);
        expect_write(14'd0, 32'h0080_0513);
        expect_write(14'd1, 32'h0080_0293);
        tx[12] = 8'hFF;
        send_tx(0);
        idle(2);
        check("f2_error",      32'(error),        32'd1);
        check("f2_done",       32'(done),         32'd0);
        check("f2_core_reset", 32'(core_reset),   32'd1);
        check("f2_in_ready",   32'(in_ready),     32'd0);
        check("f2_sb_empty",   32'(exp_q.size()), 32'd0);

        // Sync hunt prefix and an empty image.
        pulse_start();
        tx = {8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
        send_tx(0);
        idle(2);
        check("f3_done",  32'(done),         32'd1);
        check("f3_words", 32'(words_loaded), 32'd0);

        // Oversized length is rejected at LEN1.
        pulse_start();
        tx = {8'hA5, 8'h5A, 8'h01, 8'h20};
        send_tx(0);
        idle(2);
        check("f4_error",     32'(error),        32'd1);
        check("f4_in_ready",  32'(in_ready),     32'd0);
        check("f4_words",     32'(words_loaded), 32'd0);

        // Reset mid-payload after six bytes: only word 0 is written.
        pulse_start();
        expect_write(14'd0, 32'h0080_0513);
        tx = {8'hA5, 8'h5A, 8'h02, 8'h00, 8'h13, 8'h05, 8'h80, 8'h00, 8'h93, 8'h02};
        send_tx(0);
        check("f5_words_pre", 32'(words_loaded), 32'd1);
        reset_n = 1'b0;
        #2;
        check("f5_rst_words",      32'(words_loaded), 32'd0);
        check("f5_rst_mem_addr",   32'(mem_addr),     32'd0);
        check("f5_rst_mem_wdata",  mem_wdata,         32'd0);
        check("f5_rst_core_reset", 32'(core_reset),   32'd1);
        check("f5_rst_in_ready",   32'(in_ready),     32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        check("f5_sb_empty", 32'(exp_q.size()), 32'd0);
        expect_write(14'd0, 32'h0080_0513);
        expect_write(14'd1, 32'h0080_0293);
        tx = {8'hA5, 8'h5A, 8'h02, 8'h00, 8'h13, 8'h05, 8'h80, 8'h00,
              8'h93, 8'h02, 8'h80, 8'h00, 8'h87};
        send_tx(0);
        idle(2);
        check("f5_done", 32'(done), 32'd1);

        // start with in_valid in DONE: the A5 must not be consumed, so the
        // leading 5A below is discarded in SYNC0.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("f6_in_ready",   32'(in_ready),     32'd1);
        check("f6_done",       32'(done),         32'd0);
        check("f6_core_reset", 32'(core_reset),   32'd1);
        check("f6_words",      32'(words_loaded), 32'd0);
        // Payload EF BE AD DE, checksum 0x22.
        expect_write(14'd0, 32'hDEAD_BEEF);
        tx = {8'h5A, 8'hA5, 8'h5A, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_tx(4);
        idle(2);
        check("f6_final_done", 32'(done),         32'd1);
        check("f6_final_words", 32'(words_loaded), 32'd1);
        check("f6_sb_empty",   32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
